// File: rtl/b9_vector_harness_pkg.sv
// Shared constants, FSM state encoding and MISR polynomial for the b9 vector harness.
// The optional signature feature is enabled with B9_HARNESS_SIGNATURE_EN.
package b9_vector_harness_pkg;

  localparam int B9_PI_W = 41;
  localparam int B9_PO_W = 21;

  // x^21 + x^2 + 1: the x^21 term is implicit in the shift-out bit.
  localparam logic [B9_PO_W-1:0] B9_MISR_POLY = 21'h000005;

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_UNLOAD  = 2'd3
  } b9_state_e;

endpackage

// File: rtl/b9_vector_harness_misr.sv
// Multiple-input signature register folding one capture word per enable cycle.
// Only instantiated when B9_HARNESS_SIGNATURE_EN is defined.
module b9_harness_misr
  import b9_vector_harness_pkg::*;
#(
  parameter int                 W    = B9_PO_W,
  parameter logic [W-1:0]       POLY = W'(B9_MISR_POLY)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] sig_o
);

  logic [W-1:0] sig_q;
  logic [W-1:0] sig_d;

  always_comb begin
    sig_d = sig_q;
    if (en_i) begin
      sig_d = {sig_q[W-2:0], 1'b0} ^ (sig_q[W-1] ? POLY : '0) ^ data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig_o = sig_q;

endmodule

// File: rtl/b9_vector_harness.sv
// Serial-to-parallel test vector harness: LOAD -> SETTLE -> CAPTURE -> UNLOAD.
// Define B9_HARNESS_SIGNATURE_EN to add the MISR signature output.
module b9_vector_harness
  import b9_vector_harness_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int PI_W          = B9_PI_W,
  parameter int PO_W          = B9_PO_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            si_data,
  input  logic            si_valid,
  output logic            si_ready,
  input  logic            abort,
  output logic [PI_W-1:0] pi_drive,
  input  logic [PO_W-1:0] po_sense,
  output logic            so_data,
  output logic            so_valid,
  input  logic            so_ready,
  output logic            busy,
  output logic [15:0]     vec_count,
`ifdef B9_HARNESS_SIGNATURE_EN
  output logic [PO_W-1:0] signature,
`endif
  output logic [1:0]      dbg_state
);

  // Handshakes: a bit moves on a cycle where valid and ready are both high at
  // the rising edge; valid never waits on ready, and data is stable while valid
  // is high and ready is low.

  localparam int CNT_W    = $clog2((PI_W > PO_W) ? PI_W : PO_W);
  localparam int SH_IDX_W = $clog2(PI_W - 1);
  localparam int SO_IDX_W = $clog2(PO_W);

  localparam logic [CNT_W-1:0] LOAD_LAST   = CNT_W'(PI_W - 1);
  localparam logic [CNT_W-1:0] UNLOAD_LAST = CNT_W'(PO_W - 1);
  localparam logic [7:0]       SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  b9_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        settle_q, settle_d;
  logic [PI_W-2:0]   shadow_q, shadow_d;
  logic [PI_W-1:0]   pi_q, pi_d;
  logic [PO_W-1:0]   cap_q, cap_d;
  logic [15:0]       vec_q, vec_d;
  // Low through reset and until the first edge after release, so si_ready stays 0.
  logic              live_q;

  logic              load_hs;
  logic              unload_hs;
  logic [SH_IDX_W-1:0] sh_idx;
  logic [SO_IDX_W-1:0] so_idx;

  assign load_hs   = (state_q == ST_LOAD) && live_q && si_valid;
  assign unload_hs = (state_q == ST_UNLOAD) && so_ready;
  assign sh_idx    = cnt_q[SH_IDX_W-1:0];
  assign so_idx    = cnt_q[SO_IDX_W-1:0];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    settle_d = settle_q;
    shadow_d = shadow_q;
    pi_d     = pi_q;
    cap_d    = cap_q;
    vec_d    = vec_q;

    case (state_q)
      ST_LOAD: begin
        if (load_hs) begin
          if (cnt_q == LOAD_LAST) begin
            pi_d     = {si_data, shadow_q};
            cnt_d    = '0;
            settle_d = '0;
            state_d  = (SETTLE_CYCLES == 0) ? ST_CAPTURE : ST_SETTLE;
          end else begin
            shadow_d[sh_idx] = si_data;
            cnt_d            = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          settle_d = '0;
          state_d  = ST_CAPTURE;
        end else begin
          settle_d = settle_q + 8'd1;
        end
      end
      ST_CAPTURE: begin
        cap_d   = po_sense;
        cnt_d   = '0;
        state_d = ST_UNLOAD;
      end
      ST_UNLOAD: begin
        if (unload_hs) begin
          if (cnt_q == UNLOAD_LAST) begin
            vec_d   = vec_q + 16'd1;
            cnt_d   = '0;
            state_d = ST_LOAD;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_LOAD;
        cnt_d   = '0;
      end
    endcase

    // Abort overrides everything above, including a final-bit handshake.
    if (abort) begin
      state_d  = ST_LOAD;
      cnt_d    = '0;
      settle_d = '0;
      pi_d     = pi_q;
      cap_d    = cap_q;
      vec_d    = vec_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_LOAD;
      cnt_q    <= '0;
      settle_q <= '0;
      shadow_q <= '0;
      pi_q     <= '0;
      cap_q    <= '0;
      vec_q    <= '0;
      live_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      settle_q <= settle_d;
      shadow_q <= shadow_d;
      pi_q     <= pi_d;
      cap_q    <= cap_d;
      vec_q    <= vec_d;
      live_q   <= 1'b1;
    end
  end

  assign si_ready  = (state_q == ST_LOAD) && live_q;
  assign so_valid  = (state_q == ST_UNLOAD);
  assign so_data   = so_valid ? cap_q[so_idx] : 1'b0;
  assign busy      = !((state_q == ST_LOAD) && (cnt_q == '0));
  assign pi_drive  = pi_q;
  assign vec_count = vec_q;
  assign dbg_state = state_q;

`ifdef B9_HARNESS_SIGNATURE_EN
  // Folds the word being captured, so the signature is current once UNLOAD begins.
  b9_harness_misr #(
    .W    (PO_W),
    .POLY (PO_W'(B9_MISR_POLY))
  ) u_misr (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   ((state_q == ST_CAPTURE) && !abort),
    .data_i (po_sense),
    .sig_o  (signature)
  );
`endif

endmodule

// File: tb/tb_b9_vector_harness.sv
// Directed-plus-random bench for b9_vector_harness (SETTLE_CYCLES=3); also covers
// the signature output when B9_HARNESS_SIGNATURE_EN is defined.
module tb_b9_vector_harness;
  import b9_vector_harness_pkg::*;

  localparam int SETTLE = 3;
  localparam int PIW    = 41;
  localparam int POW    = 21;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic           si_data, si_valid, si_ready, abort;
  logic [PIW-1:0] pi_drive;
  logic [POW-1:0] po_sense;
  logic           so_data, so_valid, so_ready, busy;
  logic [15:0]    vec_count;
  logic [1:0]     dbg_state;
`ifdef B9_HARNESS_SIGNATURE_EN
  logic [POW-1:0] signature;
`endif

  b9_vector_harness #(
    .SETTLE_CYCLES (SETTLE),
    .PI_W          (PIW),
    .PO_W          (POW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .si_data   (si_data),
    .si_valid  (si_valid),
    .si_ready  (si_ready),
    .abort     (abort),
    .pi_drive  (pi_drive),
    .po_sense  (po_sense),
    .so_data   (so_data),
    .so_valid  (so_valid),
    .so_ready  (so_ready),
    .busy      (busy),
    .vec_count (vec_count),
`ifdef B9_HARNESS_SIGNATURE_EN
    .signature (signature),
`endif
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard / reference model ----------------
  logic [0:0]     exp_q[$];
  logic [PIW-1:0] exp_pi;
  int             exp_vec;
  logic [POW-1:0] sig_m;
  int             n_cmp = 0;
  int             n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  // Signature as polynomial arithmetic: multiply by x, reduce mod x^21+x^2+1, add data.
  function automatic logic [POW-1:0] misr_ref(input logic [POW-1:0] s, input logic [POW-1:0] d);
    logic [31:0] x;
    x = {11'b0, s} << 1;
    if (x[21]) x = x ^ 32'h0020_0005;
    return x[POW-1:0] ^ d;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic load_vector(input logic [PIW-1:0] stim, input bit abort_last);
    for (int i = 0; i < PIW; i++) begin
      if (i == 0) check("load_ready", si_ready, 1'b1);
      if (i == 1) check("busy_first_bit", busy, 1'b1);
      if (i == PIW - 1) check("pi_hold", pi_drive, exp_pi);
      si_data  = stim[i];
      si_valid = 1'b1;
      if (i == PIW - 1 && abort_last) abort = 1'b1;
      @(posedge clk); #1;
    end
    si_valid = 1'b0;
    si_data  = 1'b0;
    abort    = 1'b0;
  endtask

  task automatic wait_unload(input logic [POW-1:0] resp);
    int k;
    check("settle_entry", dbg_state, ST_SETTLE);
    k = 0;
    while (so_valid !== 1'b1 && k < 64) begin
      @(posedge clk); #1;
      k++;
    end
    // handshake cycle + SETTLE cycles + one CAPTURE cycle, then UNLOAD
    check("unload_latency", k + 1, SETTLE + 2);
    sig_m = misr_ref(sig_m, resp);
`ifdef B9_HARNESS_SIGNATURE_EN
    check("signature", signature, sig_m);
`endif
    for (int b = 0; b < POW; b++) exp_q.push_back(resp[b]);
  endtask

  task automatic unload(input int n, input int stall_after, input bit abort_last);
    int  received;
    int  budget;
    bit  stalled;
    logic [0:0] e;
    received = 0;
    budget   = 0;
    stalled  = 1'b0;
    while (received < n && budget < 500) begin
      if (stall_after >= 0 && received == stall_after + 1 && !stalled) begin
        so_ready = 1'b0;
        repeat (5) begin
          check("stall_valid", so_valid, 1'b1);
          check("stall_data", so_data, exp_q[0]);
          @(posedge clk); #1;
        end
        stalled = 1'b1;
      end
      so_ready = ($urandom_range(0, 3) != 0);
      if (so_valid && so_ready) begin
        e = exp_q.pop_front();
        check("so_data", so_data, e);
        received++;
        if (abort_last && received == n) abort = 1'b1;
      end
      @(posedge clk); #1;
      abort    = 1'b0;
      so_ready = 1'b0;
      budget++;
    end
    if (received < n) check("unload_timeout", received, n);
  endtask

  task automatic run_vector(input logic [PIW-1:0] stim, input logic [POW-1:0] resp,
                            input int stall_after);
    po_sense = resp;
    load_vector(stim, 1'b0);
    exp_pi = stim;
    check("pi_drive", pi_drive, exp_pi);
    wait_unload(resp);
    unload(POW, stall_after, 1'b0);
    exp_vec = (exp_vec + 1) & 16'hFFFF;
    check("vec_count", vec_count, exp_vec);
    check("idle_busy", busy, 1'b0);
    check("idle_ready", si_ready, 1'b1);
    check("idle_so_valid", so_valid, 1'b0);
  endtask

  function automatic logic [PIW-1:0] rand_stim();
    return PIW'({$urandom, $urandom});
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [PIW-1:0] s;
    logic [POW-1:0] r;
    rst_n = 1'b0; si_data = 1'b0; si_valid = 1'b0; abort = 1'b0;
    so_ready = 1'b0; po_sense = '0;
    exp_pi = '0; exp_vec = 0; sig_m = '0;

    #1;
    check("rst_si_ready", si_ready, 1'b0);
    check("rst_so_valid", so_valid, 1'b0);
    check("rst_so_data", so_data, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_pi_drive", pi_drive, '0);
    check("rst_vec_count", vec_count, '0);
    check("rst_state", dbg_state, ST_LOAD);
`ifdef B9_HARNESS_SIGNATURE_EN
    check("rst_signature", signature, '0);
`endif
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("pre_edge_ready", si_ready, 1'b0);
    @(posedge clk); #1;
    check("post_rst_ready", si_ready, 1'b1);
    check("post_rst_busy", busy, 1'b0);

    // All-ones load, alternating response, stall after bit 7
    run_vector({PIW{1'b1}}, 21'h15A5A5, 7);

    for (int v = 0; v < 3; v++) begin
      s = rand_stim();
      r = POW'($urandom);
      run_vector(s, r, -1);
    end

    // Abort on the final load handshake: pi_drive must not change
    s = rand_stim();
    po_sense = POW'($urandom);
    load_vector(s, 1'b1);
    check("abort_load_pi", pi_drive, exp_pi);
    check("abort_load_state", dbg_state, ST_LOAD);
    check("abort_load_busy", busy, 1'b0);
    check("abort_load_vec", vec_count, exp_vec);

    run_vector(rand_stim(), POW'($urandom), -1);

    // Abort on the last unload handshake: vec_count must not change
    s = rand_stim();
    r = POW'($urandom);
    po_sense = r;
    load_vector(s, 1'b0);
    exp_pi = s;
    wait_unload(r);
    unload(POW, -1, 1'b1);
    check("abort_unload_state", dbg_state, ST_LOAD);
    check("abort_unload_vec", vec_count, exp_vec);
    check("abort_unload_pi", pi_drive, exp_pi);
    check("abort_unload_valid", so_valid, 1'b0);

    // Asynchronous reset in the middle of SETTLE
    po_sense = POW'($urandom);
    load_vector(rand_stim(), 1'b0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    exp_pi = '0; exp_vec = 0; sig_m = '0;
    exp_q.delete();
    check("mid_rst_si_ready", si_ready, 1'b0);
    check("mid_rst_so_valid", so_valid, 1'b0);
    check("mid_rst_so_data", so_data, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_pi", pi_drive, '0);
    check("mid_rst_vec", vec_count, '0);
    check("mid_rst_state", dbg_state, ST_LOAD);
`ifdef B9_HARNESS_SIGNATURE_EN
    check("mid_rst_signature", signature, '0);
`endif
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    check("rerelease_ready", si_ready, 1'b1);

    run_vector(rand_stim(), 21'h000001, -1);
    run_vector(rand_stim(), 21'h000002, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/b9_vector_harness.md
B9_VECTOR_HARNESS -- requirements
Module: b9_vector_harness

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 2, the number of cycles to wait after applying a stimulus before sampling the response (0..255).
REQ-002 SHALL have parameter PI_W, default 41, the stimulus width; the value is fixed to match the pi00..pi40 vector.
REQ-003 SHALL have parameter PO_W, default 21, the response width; the value is fixed to match the po00..po20 vector.
REQ-004 SHALL have a single clock and an asynchronous, active-low reset, named as below.
- clk  in  1  sole clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- si_data  in  1  serial stimulus bit.
- si_valid  in  1  si_data is valid.
- si_ready  out  1  harness accepts a stimulus bit.
- abort  in  1  synchronous clear of the current transaction.
- pi_drive  out  PI_W  parallel stimulus to the DUT; bit k drives pi<k>.
- po_sense  in  PO_W  parallel response from the DUT; bit k comes from po<k>.
- so_data  out  1  serial response bit.
- so_valid  out  1  so_data is valid.
- so_ready  in  1  downstream accepts so_data.
- busy  out  1  transaction in progress.
- vec_count  out  16  count of completed vectors.
- signature  out  PO_W  MISR value; present only with the macro in REQ-020.

Function
REQ-005 SHALL implement an FSM with states LOAD, SETTLE, CAPTURE and UNLOAD.
REQ-006 In LOAD, SHALL drive si_ready=1 and shift si_data LSB-first into a shadow register on each si_valid&si_ready cycle; the bit counter counts 0..PI_W-1.
REQ-007 pi_drive SHALL change only on acceptance of bit PI_W-1: shadow plus final bit copied to pi_drive in that cycle, then -> SETTLE.
REQ-008 SETTLE SHALL last exactly SETTLE_CYCLES cycles; with SETTLE_CYCLES=0, SETTLE is skipped and the FSM goes LOAD -> CAPTURE.
REQ-009 CAPTURE SHALL last one cycle: po_sense is registered into a capture register, then -> UNLOAD.
REQ-010 In UNLOAD, SHALL assert so_valid=1 with so_data = capture bit po00 first; it advances one bit per so_valid&so_ready cycle; so_data is held stable while so_ready=0.
REQ-011 On the handshake of bit PO_W-1, SHALL increment vec_count (modulo 2^16, wraps 0xFFFF->0) and go -> LOAD with the counter at 0.
REQ-012 si_ready SHALL be 0 outside LOAD; so_valid SHALL be 0 outside UNLOAD.
REQ-013 busy SHALL be 1 unless the state is LOAD with bit counter 0.
REQ-014 abort SHALL force the next state to LOAD with counters cleared; pi_drive and vec_count are retained.
REQ-015 When abort coincides with a final-bit handshake (load or unload), abort SHALL win: no pi_drive update and no vec_count increment.

Reset
REQ-016 On rst_n=0, SHALL immediately set state=LOAD and clear both counters, pi_drive, the capture register and vec_count.
REQ-017 During reset, SHALL hold si_ready=0, so_valid=0, so_data=0 and busy=0; after release, si_ready=1 from the first clock edge.
REQ-018 A reset mid-operation SHALL discard the partial transaction with no output pulse.

Configuration
REQ-019 SHALL have exactly one compile option.
REQ-020 With B9_HARNESS_SIGNATURE_EN defined, SHALL provide the signature port as a PO_W-bit MISR (polynomial x^21+x^2+1, reset 0) that folds in the capture register once per CAPTURE cycle.
REQ-021 Without B9_HARNESS_SIGNATURE_EN, the signature port and all MISR logic SHALL be absent.

Structure
REQ-022 A shared package SHALL hold PI_W/PO_W constants, the FSM state enum and the MISR polynomial constant.
REQ-023 A single sub-module, b9_harness_misr, SHALL be instantiated only under the macro.

Verification
REQ-024 Shift 41 ones: pi_drive=0 until the 41st handshake, then 41'h1FF_FFFF_FFFF; busy=1 from the first bit.
REQ-025 SETTLE_CYCLES=3, po_sense=21'h15A5A5: so_valid rises 5 cycles after the final load handshake; serial out 1,0,1,0,0,1,0,1,... LSB-first; vec_count 0->1.
REQ-026 so_ready=0 for 5 cycles after bit 7: so_data is stable and the bit index is held; the sequence resumes unchanged.
REQ-027 Abort asserted on the 21st unload handshake: state LOAD, vec_count unchanged, pi_drive unchanged.
REQ-028 rst_n low mid-SETTLE: all outputs 0 asynchronously; after release, a fresh 41-bit load works normally.
REQ-029 With the macro, two vectors with responses 21'h000001 then 21'h000002: signature matches the reference MISR model after each CAPTURE.
